// File: rtl/jtdsp16_sio_out.sv
// jtdsp16_sio_out -- DSP16 serial output port.
//
// Takes 16-bit words written by the core into a one-word output buffer and
// shifts them out on a bit-clocked serial interface towards the audio DAC.
// Double buffered: the core may refill obuf while the previous word shifts.
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   cen          clock enable; every register advances only when cen=1
//   obuf_din     word from the core register mux
//   obuf_we      write strobe into obuf (qualified by cen)
//   lsb_first    bit order, captured when a word moves into the shifter
//   ovr_clr      clears the sticky overrun flag
//   obe          output buffer empty (core branch condition)
//   ovr          sticky overrun: obuf overwritten before it was transferred
//   sio_clk      serial bit clock, rises at each bit boundary
//   sdo          serial data
//   old          load strobe, high during bit 0 of every word
//   ose          shift enable, high during all bits of a word
`timescale 1ns/1ps
module jtdsp16_sio_out #(
    parameter int CLKDIV = 4,
    parameter int WORD   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic [WORD-1:0] obuf_din,
    input  logic            obuf_we,
    input  logic            lsb_first,
    input  logic            ovr_clr,
    output logic            obe,
    output logic            ovr,
    output logic            sio_clk,
    output logic            sdo,
    output logic            old,
    output logic            ose
);

    localparam int CW = $clog2(CLKDIV);
    localparam int IW = $clog2(WORD);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKDIV / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     bitsel;
    logic [WORD-1:0]   obuf;
    logic [WORD-1:0]   shreg;
    logic              lsb_sel;
    logic              bound;
    logic              xfer;

    assign bound = cen && (cnt == CNT_LAST);

    // Next state and the obuf->shifter transfer decision. A transfer happens
    // on a bit boundary whenever obuf holds data and the shifter is free,
    // i.e. in IDLE or right after the last bit of the current word.
    always_comb begin
        state_nxt = state;
        xfer      = 1'b0;
        if (bound) begin
            case (state)
                IDLE: begin
                    if (!obe) begin
                        xfer      = 1'b1;
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    if (idx == IDX_LAST) begin
                        if (!obe) xfer = 1'b1;
                        else      state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else if (cen) state <= state_nxt;
    end

    // Serial outputs decode directly from registered state, so they change
    // on the same clk edge as sio_clk rises.
    assign bitsel = lsb_sel ? idx : (IDX_LAST - idx);
    assign ose    = (state == SHIFT);
    assign old    = ose && (idx == '0);
    assign sdo    = ose && shreg[bitsel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            sio_clk <= 1'b0;
            obuf    <= '0;
            shreg   <= '0;
            lsb_sel <= 1'b0;
            idx     <= '0;
            obe     <= 1'b1;
            ovr     <= 1'b0;
        end else if (cen) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

            if (cnt == CNT_LAST)      sio_clk <= 1'b1;
            else if (cnt == CNT_HALF) sio_clk <= 1'b0;

            if (xfer) begin
                shreg   <= obuf;
                lsb_sel <= lsb_first;
                idx     <= '0;
            end else if (bound && state == SHIFT) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            // A write coinciding with a transfer refills the buffer that was
            // just emptied, so obe stays 0 and it is not an overrun.
            if (obuf_we) begin
                obuf <= obuf_din;
                obe  <= 1'b0;
            end else if (xfer) begin
                obe <= 1'b1;
            end

            if (obuf_we && !obe && !xfer) ovr <= 1'b1;
            else if (ovr_clr)             ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtdsp16_sio_out.sv
`timescale 1ns/1ps
module tb_jtdsp16_sio_out;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b1;
    logic [15:0] obuf_din = '0;
    logic        obuf_we = 1'b0;
    logic        lsb_first = 1'b0;
    logic        ovr_clr = 1'b0;
    logic        obe, ovr, sio_clk, sdo, old, ose;

    jtdsp16_sio_out #(.CLKDIV(4), .WORD(16)) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .obuf_din(obuf_din), .obuf_we(obuf_we), .lsb_first(lsb_first),
        .ovr_clr(ovr_clr), .obe(obe), .ovr(ovr), .sio_clk(sio_clk),
        .sdo(sdo), .old(old), .ose(ose)
    );

    always #5 clk = ~clk;

    logic cen_half = 1'b0;
    always @(negedge clk) cen = cen_half ? ~cen : 1'b1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected serial stream of each word, first bit at [15].
    logic [15:0] sb_q[$];

    // Receiver-side monitor: samples sdo on sio_clk falling edges.
    logic        prev_sclk = 1'b0;
    logic        prev_old = 1'b0;
    logic        in_word = 1'b0;
    logic        have_exp = 1'b0;
    logic [15:0] cur, exp_cur;
    int          bitcnt = 0;
    int          cyc = 0;
    int          words_started = 0;
    int          ose_run = 0, old_run = 0;
    int          last_ose_len = 0, last_old_len = 0;
    int          old_rise = 0, old_rise_prev = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_sclk = 1'b0;
            prev_old  = 1'b0;
            in_word   = 1'b0;
            have_exp  = 1'b0;
            bitcnt    = 0;
            ose_run   = 0;
            old_run   = 0;
        end else begin
            if (ose) ose_run++;
            else if (ose_run > 0) begin last_ose_len = ose_run; ose_run = 0; end
            if (old) old_run++;
            else if (old_run > 0) begin last_old_len = old_run; old_run = 0; end
            if (old && !prev_old) begin old_rise_prev = old_rise; old_rise = cyc; end
            prev_old = old;

            if (prev_sclk && !sio_clk && ose) begin
                if (old) begin
                    words_started++;
                    in_word = 1'b1;
                    bitcnt  = 0;
                    cur     = '0;
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        have_exp = 1'b0;
                        $display("FAIL unexpected_word: got a word start, expected none");
                    end else begin
                        exp_cur  = sb_q.pop_front();
                        have_exp = 1'b1;
                    end
                end
                if (in_word) begin
                    cur[15-bitcnt] = sdo;
                    bitcnt++;
                    if (bitcnt == 16) begin
                        in_word = 1'b0;
                        if (have_exp) chk("serial_word", {16'h0, cur}, {16'h0, exp_cur});
                        have_exp = 1'b0;
                    end
                end
            end
            prev_sclk = sio_clk;
        end
    end

    // Begins and ends at a negedge; holds the strobe until a cen cycle takes it.
    task automatic write_word(input logic [15:0] d, input logic lsb);
        int n;
        obuf_din  = d;
        lsb_first = lsb;
        obuf_we   = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!cen && n < 10);
        @(negedge clk);
        obuf_we = 1'b0;
    endtask

    task automatic wait_obe;
        int n = 0;
        while (!obe && n < 2000) begin @(negedge clk); n++; end
        if (!obe) chk("obe_timeout", 32'(obe), 32'h1);
    endtask

    task automatic drain;
        int n = 0;
        while ((sb_q.size() != 0 || in_word || ose || !obe) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("drain_timeout", 32'(sb_q.size()), 32'h0);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] din;
        logic        lsb;
        logic [15:0] stream;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        int gap, ws;
        logic pv;

        tbl[0] = '{din: 16'hA5C3, lsb: 1'b0, stream: 16'hA5C3};
        tbl[1] = '{din: 16'h0001, lsb: 1'b1, stream: 16'h8000};
        tbl[2] = '{din: 16'h1234, lsb: 1'b1, stream: 16'h2C48};
        tbl[3] = '{din: 16'h8000, lsb: 1'b1, stream: 16'h0001};
        tbl[4] = '{din: 16'hF00D, lsb: 1'b0, stream: 16'hF00D};
        tbl[5] = '{din: 16'hF00D, lsb: 1'b1, stream: 16'hB00F};

        repeat (3) @(negedge clk);
        chk("rst_obe", 32'(obe), 32'h1);
        chk("rst_ovr", 32'(ovr), 32'h0);
        chk("rst_sio_clk", 32'(sio_clk), 32'h0);
        chk("rst_sdo", 32'(sdo), 32'h0);
        chk("rst_old", 32'(old), 32'h0);
        chk("rst_ose", 32'(ose), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Table vectors, written as soon as the buffer frees up.
        for (int i = 0; i < 6; i++) begin
            wait_obe();
            sb_q.push_back(tbl[i].stream);
            write_word(tbl[i].din, tbl[i].lsb);
        end
        drain();
        chk("table_ovr", 32'(ovr), 32'h0);

        // Single word from IDLE: bit timing and obe handling.
        sb_q.push_back(16'hA5C3);
        write_word(16'hA5C3, 1'b0);
        chk("write_obe_low", 32'(obe), 32'h0);
        n = 0;
        while (!ose && n < 20) begin @(negedge clk); n++; end
        chk("xfer_obe_high", 32'(obe), 32'h1);
        drain();
        chk("single_ose_len", 32'(last_ose_len), 32'd64);
        chk("single_old_len", 32'(last_old_len), 32'd4);

        // Back-to-back: no gap, second load strobe one word period later.
        sb_q.push_back(16'hFFFF);
        write_word(16'hFFFF, 1'b0);
        wait_obe();
        sb_q.push_back(16'h0000);
        write_word(16'h0000, 1'b0);
        drain();
        gap = old_rise - old_rise_prev;
        chk("b2b_old_gap", 32'(gap), 32'd64);
        chk("b2b_ose_len", 32'(last_ose_len), 32'd128);
        chk("b2b_ovr", 32'(ovr), 32'h0);

        // Overrun: two writes right after a boundary, before the transfer.
        n = 0;
        pv = sio_clk;
        @(negedge clk);
        while (!(sio_clk && !pv) && n < 20) begin pv = sio_clk; @(negedge clk); n++; end
        write_word(16'h1111, 1'b0);
        sb_q.push_back(16'h2222);
        write_word(16'h2222, 1'b0);
        chk("ovr_set", 32'(ovr), 32'h1);
        drain();
        chk("ovr_sticky", 32'(ovr), 32'h1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        chk("ovr_clr", 32'(ovr), 32'h0);

        // Half-rate cen: same data, doubled periods.
        cen_half = 1'b1;
        sb_q.push_back(16'hA5C3);
        write_word(16'hA5C3, 1'b0);
        drain();
        chk("half_ose_len", 32'(last_ose_len), 32'd128);
        chk("half_old_len", 32'(last_old_len), 32'd8);

        // A strobe during a cen=0 cycle must be ignored.
        ws = words_started;
        @(negedge clk);
        #1;
        if (cen) begin @(negedge clk); #1; end
        obuf_din = 16'hDEAD;
        obuf_we  = 1'b1;
        @(posedge clk);
        #1;
        obuf_we  = 1'b0;
        repeat (60) @(negedge clk);
        chk("cen0_we_obe", 32'(obe), 32'h1);
        chk("cen0_we_nowords", 32'(words_started), 32'(ws));
        cen_half = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of bit 5.
        sb_q.push_back(16'h5A5A);
        write_word(16'h5A5A, 1'b0);
        n = 0;
        while (!old && n < 20) begin @(negedge clk); n++; end
        repeat (21) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_obe", 32'(obe), 32'h1);
        chk("midrst_ose", 32'(ose), 32'h0);
        chk("midrst_old", 32'(old), 32'h0);
        chk("midrst_sdo", 32'(sdo), 32'h0);
        chk("midrst_sio_clk", 32'(sio_clk), 32'h0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        ws = words_started;
        n = 0;
        repeat (200) begin
            @(negedge clk);
            if (ose) n++;
        end
        chk("postrst_ose_cycles", 32'(n), 32'h0);
        chk("postrst_nowords", 32'(words_started), 32'(ws));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtdsp16_sio_out.md
Name: jtdsp16_sio_out

Overview:
- Serial output port of the DSP16 core; sits directly downstream of the core.
- Consumes 16-bit words written from the core's register bus to the output buffer (obuf).
- Serialises each word onto a bit-clocked pin set (sio_clk, sdo, old, ose) that feeds the audio DAC/mixer.
- Double-buffered: the core can write the next word while the current one shifts out, and polls the obe flag as a branch condition.

Parameters:
- CLKDIV, 4, cen ticks per serial bit; even, >=2.
- WORD, 16, bits per serial word.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cen  in  1  clock enable; all state advances only when cen=1
- obuf_din  in  WORD  word from core register mux
- obuf_we  in  1  write strobe; sampled only when cen=1
- lsb_first  in  1  0: MSB shifted first; 1: LSB first; sampled at word transfer
- ovr_clr  in  1  clears ovr; sampled when cen=1
- obe  out  1  output buffer empty status to core condition logic
- ovr  out  1  sticky overrun flag
- sio_clk  out  1  serial bit clock
- sdo  out  1  serial data
- old  out  1  output load strobe, high for first bit period of each word
- ose  out  1  output shift enable, high for all WORD bit periods of a word

Behaviour:
- Reset (async, any time, including mid-word):
  - obe=1, ovr=0, sio_clk=0, sdo=0, old=0, ose=0.
  - Divider cnt=0, state IDLE, obuf and shift register cleared.
  - Partial word is discarded; nothing resumes after reset release.
- Divider:
  - cnt counts 0..CLKDIV-1 on cen, wraps to 0 and runs freely in all states.
  - Bit boundary = cen cycle where cnt==CLKDIV-1.
  - sio_clk (registered) goes 1 on a bit boundary and 0 when cnt reaches CLKDIV/2-1 on cen. This gives CLKDIV/2 ticks high and CLKDIV/2 ticks low per bit.
- Write:
  - cen & obuf_we loads obuf_din into obuf and sets obe=0.
  - A write while obe=0 (buffer not yet transferred) overwrites obuf (last write wins) and sets ovr=1.
  - If ovr_clr and an overrunning write occur together, the set wins.
- States:
  - IDLE: ose=0, old=0, sdo=0. At a bit boundary with obe=0: copy obuf to the shift register, set obe=1, set bit index to 0, enter SHIFT.
  - SHIFT: at each bit boundary, sdo presents the next bit (bit WORD-1-idx if MSB-first, bit idx if LSB-first) and idx increments.
    - old=1 only while idx==0; ose=1 throughout.
    - After the boundary that ends bit WORD-1:
      - if obe=0, transfer the new word immediately (no gap; old pulses again).
      - otherwise go to IDLE (ose, old, sdo drop to 0).
- Transfer and write in the same cen cycle:
  - The shift register takes the old obuf content.
  - The new data lands in obuf and obe stays 0. This does not count as an overrun.
- Timing and latency:
  - Data, old and ose change on the same clk edge as sio_clk rises; the receiver samples on the sio_clk falling edge.
  - Write-to-first-bit latency ranges from 1 to CLKDIV cen ticks, depending on divider phase.
- cen=0 freezes all state and outputs.

Test Plan:
- Reset mid-word: assert rst during bit 5 of a word -> same clk: obe=1, ose=0, old=0, sdo=0, sio_clk=0; after release, no further bits until a new write.
- Single word, CLKDIV=4, cen=1, lsb_first=0: write 16'hA5C3 in IDLE -> at next boundary obe=1, ose=1 for 64 clk, old=1 for first 4 clk, sdo sequence 1010010111000011, then IDLE.
- LSB-first: write 16'h0001 with lsb_first=1 -> sdo=1 in bit period 0 only, 0 for the remaining 15.
- Back-to-back: write 16'hFFFF, then 16'h0000 while the first is shifting -> no IDLE gap between words, second old pulse exactly 64 clk after the first, ovr stays 0.
- Overrun: write 16'h1111 and 16'h2222 before the next boundary -> ovr=1, word shifted out is 16'h2222; ovr_clr pulse -> ovr=0.
- cen gating: cen high every 2nd clk -> every output period doubles (word spans 128 clk), data is identical; a write with obuf_we=1 and cen=0 is ignored.
